// File: rtl/regfile_pkg.sv
// Shared constants, register word type and one-hot helper for the register file.
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 16;
    localparam int ADDR_WIDTH = 4;

    typedef logic [DATA_WIDTH-1:0] word_t;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    function automatic logic is_onehot16(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/register_file_onehot_check.sv
// Combinational validity check on the decoder's destination select.
module onehot_check
    import regfile_pkg::*;
(
    input  logic [15:0] sel_i,
    output logic        valid_o
);

    assign valid_o = is_onehot16(sel_i);

endmodule

// File: rtl/register_file.sv
// 16 x 32-bit register file: one-cycle write-back stage, two registered read ports,
// sticky error on non-one-hot write select. Define REGFILE_BYPASS_EN to forward wb data to reads.
module register_file
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [NUM_REGS-1:0]   wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic                  err_clr,
    output logic                  sel_err
);

    logic                sel_valid;
    logic                wb_valid_q, wb_valid_d;
    logic [NUM_REGS-1:0] wb_sel_q,   wb_sel_d;
    word_t               wb_data_q,  wb_data_d;
    logic                sel_err_q,  sel_err_d;
    word_t               rd_a_q,     rd_a_d;
    word_t               rd_b_q,     rd_b_d;
    word_t               regs_q [NUM_REGS];

    onehot_check u_onehot_check (
        .sel_i   (wr_sel),
        .valid_o (sel_valid)
    );

    always_comb begin
        wb_valid_d = wr_en & sel_valid;
        wb_sel_d   = wb_sel_q;
        wb_data_d  = wb_data_q;
        if (wr_en && sel_valid) begin
            wb_sel_d  = wr_sel;
            wb_data_d = wr_data;
        end
    end

    // A new bad write takes priority over a coincident clear.
    always_comb begin
        sel_err_d = sel_err_q;
        if (wr_en && !sel_valid)
            sel_err_d = 1'b1;
        else if (err_clr)
            sel_err_d = 1'b0;
    end

    always_comb begin
        rd_a_d = regs_q[rd_addr_a];
        rd_b_d = regs_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wb_valid_q && wb_sel_q[rd_addr_a])
            rd_a_d = wb_data_q;
        if (wb_valid_q && wb_sel_q[rd_addr_b])
            rd_b_d = wb_data_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_sel_q   <= '0;
            wb_data_q  <= '0;
            sel_err_q  <= 1'b0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_sel_q   <= wb_sel_d;
            wb_data_q  <= wb_data_d;
            sel_err_q  <= sel_err_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
        end
    end

    // Each register commits from the write-back stage when its select bit is set.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                regs_q[gi] <= '0;
            else if (wb_valid_q && wb_sel_q[gi])
                regs_q[gi] <= wb_data_q;
        end
    end

    assign rd_data_a = rd_a_q;
    assign rd_data_b = rd_b_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file; expectations follow the build's REGFILE_BYPASS_EN setting.
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_sel;
    logic [31:0] wr_data;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        err_clr;
    logic        sel_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    // Reference state: committed array plus the single pending write-back entry.
    logic [31:0] m_regs [16];
    logic        m_pv;
    logic [15:0] m_psel;
    logic [31:0] m_pdata;
    logic        m_err;

    logic [31:0] exp_a_q [$];
    logic [31:0] exp_b_q [$];
    logic        exp_e_q [$];

    register_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .err_clr   (err_clr),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_pv = 1'b0; m_psel = '0; m_pdata = '0; m_err = 1'b0;
    endtask

    // Called at a falling edge: drive, predict, clock once, compare at the next falling edge.
    task automatic cycle(input logic we, input logic [15:0] sel, input logic [31:0] data,
                         input logic [3:0] ra, input logic [3:0] rb, input logic clr);
        logic [31:0] ea, eb, got_a, got_b;
        logic        ee, good, got_e;
        wr_en = we; wr_sel = sel; wr_data = data;
        rd_addr_a = ra; rd_addr_b = rb; err_clr = clr;
        ea = (BYP && m_pv && m_psel[ra]) ? m_pdata : m_regs[ra];
        eb = (BYP && m_pv && m_psel[rb]) ? m_pdata : m_regs[rb];
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        if (m_pv)
            for (int i = 0; i < 16; i++) if (m_psel[i]) m_regs[i] = m_pdata;
        good = ($countones(sel) == 1);
        m_pv = we && good;
        if (m_pv) begin m_psel = sel; m_pdata = data; end
        if (we && !good) m_err = 1'b1;
        else if (clr)    m_err = 1'b0;
        exp_e_q.push_back(m_err);
        @(posedge clk);
        @(negedge clk);
        n_cyc++;
        $display("[TB] cyc %0d we=%0b sel=%04h data=%08h ra=%0d rb=%0d clr=%0b -> a=%08h b=%08h err=%0b",
                 n_cyc, we, sel, data, ra, rb, clr, rd_data_a, rd_data_b, sel_err);
        got_a = exp_a_q.pop_front();
        got_b = exp_b_q.pop_front();
        got_e = exp_e_q.pop_front();
        check("rd_a", rd_data_a, got_a);
        check("rd_b", rd_data_b, got_b);
        check("sel_err", {31'd0, sel_err}, {31'd0, got_e});
    endtask

    task automatic idle_read(input logic [3:0] ra, input logic [3:0] rb);
        cycle(1'b0, 16'h0, 32'h0, ra, rb, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 0; wr_sel = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; err_clr = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check("rst_rd_a", rd_data_a, 32'h0);
        check("rst_rd_b", rd_data_b, 32'h0);
        check("rst_err", {31'd0, sel_err}, 32'h0);
        rst_n = 1'b1;

        // Write then read, latency at E0 / E1 / E2
        cycle(1'b1, 16'h0020, 32'hDEADBEEF, 4'd5, 4'd5, 1'b0);
        check("wr_e0_old", rd_data_a, 32'h0);
        idle_read(4'd5, 4'd0);
        check("wr_e1", rd_data_a, BYP ? 32'hDEADBEEF : 32'h0);
        idle_read(4'd5, 4'd5);
        check("wr_e2_a", rd_data_a, 32'hDEADBEEF);
        check("wr_e2_b", rd_data_b, 32'hDEADBEEF);

        // Back-to-back writes to register 3
        cycle(1'b1, 16'h0008, 32'h11111111, 4'd3, 4'd3, 1'b0);
        cycle(1'b1, 16'h0008, 32'h22222222, 4'd3, 4'd3, 1'b0);
        if (BYP) check("b2b_first", rd_data_a, 32'h11111111);
        idle_read(4'd3, 4'd3);
        if (BYP) check("b2b_second", rd_data_a, 32'h22222222);
        idle_read(4'd3, 4'd5);
        check("b2b_final", rd_data_a, 32'h22222222);

        // Invalid selects, sticky error, clear vs set priority
        cycle(1'b1, 16'h0003, 32'hBAD0BAD0, 4'd0, 4'd1, 1'b0);
        check("bad_err_set", {31'd0, sel_err}, 32'd1);
        cycle(1'b1, 16'h0000, 32'hBAD1BAD1, 4'd0, 4'd1, 1'b0);
        idle_read(4'd0, 4'd1);
        check("bad_r0", rd_data_a, 32'h0);
        check("bad_r1", rd_data_b, 32'h0);
        cycle(1'b1, 16'h0101, 32'hBAD2BAD2, 4'd0, 4'd8, 1'b1);
        check("clr_vs_set", {31'd0, sel_err}, 32'd1);
        cycle(1'b0, 16'h0, 32'h0, 4'd8, 4'd0, 1'b1);
        check("err_cleared", {31'd0, sel_err}, 32'd0);

        // Dual port
        cycle(1'b1, 16'h8000, 32'hCAFEF00D, 4'd0, 4'd0, 1'b0);
        cycle(1'b1, 16'h0001, 32'h00000001, 4'd0, 4'd0, 1'b0);
        idle_read(4'd0, 4'd0);
        idle_read(4'd15, 4'd0);
        check("dp_a15", rd_data_a, 32'hCAFEF00D);
        check("dp_b0", rd_data_b, 32'h00000001);
        idle_read(4'd15, 4'd15);
        check("dp_same", rd_data_b, 32'hCAFEF00D);

        // Randomised traffic with occasional bad selects
        for (int k = 0; k < 60; k++) begin
            logic [15:0] s;
            s = 16'h1 << $urandom_range(15);
            if ($urandom_range(7) == 0) s = 16'($urandom);
            cycle(1'($urandom_range(1)), s, $urandom, 4'($urandom_range(15)),
                  4'($urandom_range(15)), ($urandom_range(5) == 0));
        end

        // Reset mid-traffic discards the pending write
        cycle(1'b1, 16'h0080, 32'h77777777, 4'd7, 4'd7, 1'b0);
        wr_en = 1'b0;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("mid_rst_a", rd_data_a, 32'h0);
        check("mid_rst_b", rd_data_b, 32'h0);
        check("mid_rst_err", {31'd0, sel_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_read(4'd7, 4'd3);
        idle_read(4'd7, 4'd15);
        check("rst_discard", rd_data_a, 32'h0);
        check("rst_r15", rd_data_b, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
